skid_buffer: RTL and testbench
==============================

SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the payload width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream producer offers in_data this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-006 SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream register stage accepts out_data this cycle.
REQ-009 SHALL have port out_data, output, WIDTH bits: the payload presented to the downstream register stage.

Function
REQ-010 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-011 SHALL hold two storage entries: main (drives out_data) and skid (overflow).
REQ-012 SHALL implement three states:
  - EMPTY: no entries stored.
  - BUSY: main is valid.
  - FULL: main and skid are both valid.
REQ-013 SHALL drive out_valid = 1 exactly in BUSY and FULL.
REQ-014 SHALL drive in_ready = 1 exactly in EMPTY and BUSY, decoded from registered state only, with no combinational path from out_ready.
REQ-015 In EMPTY with in_fire, SHALL load main from in_data and go to BUSY, so data appears on out_data one cycle after acceptance.
REQ-016 In BUSY with in_fire and out_fire together, SHALL load main from in_data and stay in BUSY, giving full throughput of one item per cycle.
REQ-017 In BUSY with in_fire and no out_fire, SHALL load skid from in_data, leave main unchanged, and go to FULL.
REQ-018 In BUSY with out_fire and no in_fire, SHALL go to EMPTY.
REQ-019 In FULL with out_fire, SHALL copy skid into main and go to BUSY; in_valid is ignored because in_ready = 0.
REQ-020 In any state with neither fire, SHALL hold all state and data.
REQ-021 While out_valid = 1 and out_ready = 0, SHALL keep out_data stable.
REQ-022 SHALL deliver items in acceptance order, with none lost or duplicated.
REQ-023 In EMPTY, out_data SHALL retain the last value held by main, and that value carries no meaning.
REQ-024 Data storage SHALL be loaded only through per-entry enables; no entry changes without its enable.

Reset
REQ-025 While reset = 1 at a rising clk edge, SHALL go to EMPTY and clear main and skid to 0.
REQ-026 While reset is high, SHALL force in_ready = 0 and out_valid = 0.
REQ-027 If reset is asserted mid-operation, in-flight entries SHALL be discarded.
REQ-028 In the first cycle after reset deasserts, in_ready SHALL be 1.

Structure
REQ-029 A shared package SHALL hold the state typedef (EMPTY, BUSY, FULL; 2 bits) and the default WIDTH constant.
REQ-030 Each of main and skid SHALL be one instance of the existing enabled register sub-module, register #(WIDTH).
REQ-031 main's enable SHALL be (EMPTY & in_fire) | (BUSY & in_fire & out_fire) | (FULL & out_fire).
REQ-032 main's data input SHALL be a 2:1 selection between in_data and skid, choosing skid in FULL.
REQ-033 skid's enable SHALL be BUSY & in_fire & ~out_fire.
REQ-034 The state register SHALL be a separate 2-bit flop with synchronous reset.

Verification
REQ-035 Reset check: hold reset for 5 cycles, then release -> in_ready = 0 and out_valid = 0 during reset; in_ready = 1, out_valid = 0 and out_data = 0 in the first cycle after.
REQ-036 Streaming check: out_ready = 1 and in_valid = 1 with data 1, 2, 3, 4 on consecutive cycles -> out_data shows 1, 2, 3, 4 on consecutive cycles, each one cycle after acceptance, with no bubbles.
REQ-037 Backpressure check: accept 0xA then 0xB with out_ready = 0 -> state FULL, in_ready = 0, out_data held at 0xA for at least 3 stall cycles.
REQ-038 Drain check: from FULL (0xA, 0xB), raise out_ready -> 0xA then 0xB are delivered, state returns to EMPTY, and in_ready returns to 1 after the first drain.
REQ-039 Simultaneous check: in BUSY holding 0x5, drive in_fire (0x6) and out_fire together -> state stays BUSY, out_data = 0x6 next cycle, no skid load.
REQ-040 Mid-operation reset: assert reset in FULL -> EMPTY next cycle, out_valid = 0, and the stored 0xA and 0xB are never delivered.

Source files
------------

// File: rtl/skid_buffer_pkg.sv
// Shared types and constants for the two-entry skid buffer.
package skid_buffer_pkg;

   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StBusy  = 2'b01,
      StFull  = 2'b10
   } state_e;

   localparam int unsigned DefaultWidth = 32;

endpackage

// File: rtl/skid_buffer_register.sv
// Enabled data register with synchronous active-high clear.
module register #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer; in_ready comes from registered state only so the
// upstream handshake never sees a combinational path from out_ready.
module skid_buffer
   import skid_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   state_e           state_q, state_d;
   logic             in_fire, out_fire;
   logic             main_en, skid_en;
   logic [WIDTH-1:0] main_d, main_q, skid_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StEmpty: if (in_fire) state_d = StBusy;
         StBusy: begin
            if (in_fire && !out_fire) begin
               state_d = StFull;
            end else if (!in_fire && out_fire) begin
               state_d = StEmpty;
            end
         end
         StFull:  if (out_fire) state_d = StBusy;
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         StEmpty: in_ready = 1'b1;
         StBusy: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
         end
         StFull:  out_valid = 1'b1;
         default: ;
      endcase
      // Handshakes are masked for the whole reset assertion, not just after the edge.
      if (reset) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
      end
   end

   assign main_en = ((state_q == StEmpty) & in_fire)
                  | ((state_q == StBusy) & in_fire & out_fire)
                  | ((state_q == StFull) & out_fire);
   assign skid_en = (state_q == StBusy) & in_fire & ~out_fire;
   assign main_d  = (state_q == StFull) ? skid_q : in_data;

   register #(
      .WIDTH(WIDTH)
   ) u_main (
      .clk_i(clk),
      .rst_i(reset),
      .en_i (main_en),
      .d_i  (main_d),
      .q_o  (main_q)
   );

   register #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk_i(clk),
      .rst_i(reset),
      .en_i (skid_en),
      .d_i  (in_data),
      .q_o  (skid_q)
   );

   assign out_data = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed-vector bench for skid_buffer plus a scoreboarded ordering sequence.
module tb_skid_buffer;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   skid_buffer #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );

   // Inputs applied before an edge; expected outputs are those seen just before that edge.
   typedef struct {
      string        name;
      logic         rst;
      logic         iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         ir;
      logic         ov;
      logic         chk;
      logic [W-1:0] od;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic add(input string n, input logic r, input logic iv, input logic [W-1:0] id,
                      input logic ordy, input logic ir, input logic ov, input logic c,
                      input logic [W-1:0] od);
      vec_t v;
      v.name = n; v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy;
      v.ir = ir; v.ov = ov; v.chk = c; v.od = od;
      vecs.push_back(v);
   endtask

   logic [W-1:0] model_q[$];
   logic [W-1:0] next_val;
   logic         f_in, f_out;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      for (int i = 0; i < 5; i++) add("reset_hold", 1, 0, 0, 0, 0, 0, 0, 0);
      add("post_reset", 0, 1, 32'h1, 1, 1, 0, 1, 32'h0);
      add("stream_1",   0, 1, 32'h2, 1, 1, 1, 1, 32'h1);
      add("stream_2",   0, 1, 32'h3, 1, 1, 1, 1, 32'h2);
      add("stream_3",   0, 1, 32'h4, 1, 1, 1, 1, 32'h3);
      add("stream_4",   0, 0, 32'h0, 1, 1, 1, 1, 32'h4);
      add("stream_end", 0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
      add("bp_acc_a",   0, 1, 32'hA, 0, 1, 0, 0, 32'h0);
      add("bp_acc_b",   0, 1, 32'hB, 0, 1, 1, 1, 32'hA);
      add("bp_stall1",  0, 1, 32'hC, 0, 0, 1, 1, 32'hA);
      add("bp_stall2",  0, 1, 32'hD, 0, 0, 1, 1, 32'hA);
      add("bp_stall3",  0, 0, 32'h0, 0, 0, 1, 1, 32'hA);
      add("drain_a",    0, 0, 32'h0, 1, 0, 1, 1, 32'hA);
      add("drain_b",    0, 0, 32'h0, 1, 1, 1, 1, 32'hB);
      add("drain_end",  0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
      add("sim_load5",  0, 1, 32'h5, 0, 1, 0, 0, 32'h0);
      add("sim_both",   0, 1, 32'h6, 1, 1, 1, 1, 32'h5);
      add("sim_after",  0, 0, 32'h0, 0, 1, 1, 1, 32'h6);
      add("sim_drain",  0, 0, 32'h0, 1, 1, 1, 1, 32'h6);
      add("sim_end",    0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
      add("mr_acc_a",   0, 1, 32'hA, 0, 1, 0, 0, 32'h0);
      add("mr_acc_b",   0, 1, 32'hB, 0, 1, 1, 1, 32'hA);
      add("mr_reset",   1, 0, 32'h0, 1, 0, 0, 0, 32'h0);
      add("mr_after",   0, 0, 32'h0, 1, 1, 0, 1, 32'h0);
      add("mr_nodeliv", 0, 0, 32'h0, 1, 1, 0, 0, 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].id;
         out_ready = vecs[i].ordy;
         #1;
         check({vecs[i].name, ".in_ready"}, W'(in_ready), W'(vecs[i].ir));
         check({vecs[i].name, ".out_valid"}, W'(out_valid), W'(vecs[i].ov));
         if (vecs[i].chk) check({vecs[i].name, ".out_data"}, out_data, vecs[i].od);
      end

      // Ordering under irregular valid/ready: a depth-2 FIFO model predicts every handshake.
      next_val = 32'h100;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         reset = 1'b0;
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = next_val;
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         check("ord.in_ready", W'(in_ready), W'(model_q.size() < 2));
         check("ord.out_valid", W'(out_valid), W'(model_q.size() != 0));
         if (model_q.size() != 0) check("ord.out_data", out_data, model_q[0]);
         f_in  = in_valid & (model_q.size() < 2);
         f_out = out_ready & (model_q.size() != 0);
         if (f_out) void'(model_q.pop_front());
         if (f_in) begin
            model_q.push_back(next_val);
            next_val++;
         end
      end

      // Bounded drain of whatever the model still holds.
      for (int c = 0; c < 10 && model_q.size() != 0; c++) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         #1;
         check("drain.out_valid", W'(out_valid), 32'h1);
         check("drain.out_data", out_data, model_q[0]);
         void'(model_q.pop_front());
      end
      @(negedge clk);
      #1;
      check("drain.model_empty", W'(model_q.size()), 32'h0);
      check("drain.final_valid", W'(out_valid), 32'h0);
      check("drain.final_ready", W'(in_ready), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
